// File: rtl/key_event_fifo.sv
// key_event_fifo: repeat-suppressing key event capture.
// The first debounced pulse of a press is accepted and snapshots the switch
// bank into a small FIFO. Pulses that arrive while the key is still held are
// discarded. The FIFO is drained by CPU read strobes.
module key_event_fifo #(
    parameter int unsigned REPEAT_WIN = 50000,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     key_pulse,
    input  logic [DATA_W-1:0]        sw,
    input  logic                     pop,
    input  logic                     ovf_clr,
    output logic [DATA_W-1:0]        head_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     held
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned GAP_W = $clog2(REPEAT_WIN) + 1;

    typedef enum logic {
        ARMED = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [GAP_W-1:0]   gap_nxt;
    logic               accept;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_r;

    logic               is_empty;
    logic               is_full;
    logic               do_pop;
    logic               do_push;
    logic               drop;

    // Repeat filter state register and idle-gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARMED;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Repeat filter next state: accept the first pulse, then require
    // REPEAT_WIN consecutive idle cycles before re-arming.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        accept    = 1'b0;
        case (state)
            ARMED: begin
                if (key_pulse) begin
                    accept    = 1'b1;
                    state_nxt = HELD;
                    gap_nxt   = '0;
                end
            end
            HELD: begin
                if (key_pulse) begin
                    // A repeat, including one on the terminal count, restarts the gap.
                    gap_nxt = '0;
                end else if (gap_cnt == GAP_W'(REPEAT_WIN - 1)) begin
                    state_nxt = ARMED;
                    gap_nxt   = '0;
                end else begin
                    gap_nxt = gap_cnt + GAP_W'(1);
                end
            end
            default: begin
                state_nxt = ARMED;
                gap_nxt   = '0;
            end
        endcase
    end

    // FIFO control decode: a pop on a full FIFO makes room for a same-cycle push.
    always_comb begin
        is_empty = (cnt == '0);
        is_full  = (cnt == CNT_W'(DEPTH));
        do_pop   = pop && !is_empty;
        do_push  = accept && (!is_full || do_pop);
        drop     = accept && is_full && !do_pop;
    end

    // FIFO storage; contents need no reset because the empty gate hides them.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr] <= sw;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (a new drop beats a clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            ovf_r  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (drop) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Outputs decoded from registers only.
    always_comb begin
        count     = cnt;
        empty     = is_empty;
        full      = is_full;
        overflow  = ovf_r;
        held      = (state == HELD);
        head_data = is_empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: tb/tb_key_event_fifo.sv
// Testbench for key_event_fifo: vector table, directed corner sequences and
// randomized traffic, all checked against a queue-based reference model.
module tb_key_event_fifo;

    localparam int RW    = 8;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_pulse = 1'b0;
    logic [15:0] sw = '0;
    logic        pop = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [15:0] head_data;
    logic        empty;
    logic        full;
    logic [2:0]  count;
    logic        overflow;
    logic        held;

    key_event_fifo #(
        .REPEAT_WIN (RW),
        .DATA_W     (16),
        .DEPTH      (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_pulse (key_pulse),
        .sw        (sw),
        .pop       (pop),
        .ovf_clr   (ovf_clr),
        .head_data (head_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .held      (held)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: a pulse is a new press only if at least RW idle
    // cycles have passed since the previous pulse of any kind.
    logic [15:0] mq[$];
    int          quiet = RW;
    logic        movf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [22:0] dut_vec();
        return {count, head_data, held, overflow, empty, full};
    endfunction

    function automatic logic [22:0] model_vec();
        logic [15:0] h;
        h = (mq.size() > 0) ? mq[0] : 16'h0;
        return {3'(mq.size()), h, (quiet < RW), movf, (mq.size() == 0), (mq.size() == DEPTH)};
    endfunction

    task automatic model_step(input logic r, input logic kp, input logic [15:0] s,
                              input logic p, input logic oc);
        logic acc;
        if (r) begin
            mq.delete();
            quiet = RW;
            movf  = 1'b0;
        end else begin
            acc = kp && (quiet >= RW);
            if (kp) quiet = 0;
            else if (quiet < RW) quiet++;
            if (p && mq.size() > 0) void'(mq.pop_front());
            if (oc) movf = 1'b0;
            if (acc) begin
                if (mq.size() < DEPTH) mq.push_back(s);
                else movf = 1'b1;
            end
        end
    endtask

    // One clock with the given inputs, then compare the DUT to the model.
    task automatic tick(input logic r, input logic kp, input logic [15:0] s,
                        input logic p, input logic oc, input string name);
        rst = r; key_pulse = kp; sw = s; pop = p; ovf_clr = oc;
        @(posedge clk);
        #1;
        rst = 1'b0; key_pulse = 1'b0; pop = 1'b0; ovf_clr = 1'b0;
        model_step(r, kp, s, p, oc);
        check(name, 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic idle(input int n, input string name);
        for (int i = 0; i < n; i++) tick(0, 0, 16'h0, 0, 0, name);
    endtask

    task automatic press(input logic [15:0] v, input string name);
        tick(0, 1, v, 0, 0, name);
        idle(RW, name);
    endtask

    typedef struct {
        logic        r;
        logic        kp;
        logic [15:0] s;
        logic        p;
        logic        oc;
        logic [2:0]  ecount;
        logic [15:0] ehead;
        logic        eheld;
        logic        eovf;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(input logic r, input logic kp, input logic [15:0] s,
                                input logic p, input logic oc, input logic [2:0] ec,
                                input logic [15:0] eh, input logic ehl, input logic eo);
        vec_t v;
        v.r = r; v.kp = kp; v.s = s; v.p = p; v.oc = oc;
        v.ecount = ec; v.ehead = eh; v.eheld = ehl; v.eovf = eo;
        return v;
    endfunction

    initial begin
        // Reset, single press, re-arm timing, pop, pop-on-empty, push+pop on empty.
        vt[0]  = mk(1, 0, 16'h0000, 0, 0, 3'd0, 16'h0000, 0, 0);
        vt[1]  = mk(0, 1, 16'h00A5, 0, 0, 3'd1, 16'h00A5, 1, 0);
        for (int i = 2; i <= 8; i++) vt[i] = mk(0, 0, 16'h0000, 0, 0, 3'd1, 16'h00A5, 1, 0);
        vt[9]  = mk(0, 0, 16'h0000, 0, 0, 3'd1, 16'h00A5, 0, 0);
        vt[10] = mk(0, 0, 16'h0000, 1, 0, 3'd0, 16'h0000, 0, 0);
        vt[11] = mk(0, 0, 16'h0000, 1, 0, 3'd0, 16'h0000, 0, 0);
        vt[12] = mk(0, 1, 16'h1234, 1, 0, 3'd1, 16'h1234, 1, 0);
        vt[13] = mk(0, 0, 16'h0000, 0, 1, 3'd1, 16'h1234, 1, 0);

        for (int i = 0; i < 14; i++) begin
            tick(vt[i].r, vt[i].kp, vt[i].s, vt[i].p, vt[i].oc, $sformatf("vec%0d_model", i));
            check($sformatf("vec%0d", i),
                  32'({count, head_data, held, overflow, empty, full}),
                  32'({vt[i].ecount, vt[i].ehead, vt[i].eheld, vt[i].eovf,
                       (vt[i].ecount == 3'd0), (vt[i].ecount == 3'd4)}));
        end

        // Held key: six pulses five cycles apart yield one entry.
        tick(1, 0, 16'h0, 0, 0, "held_rst");
        tick(0, 1, 16'h0011, 0, 0, "held_p0");
        for (int k = 1; k < 6; k++) begin
            idle(4, "held_gap");
            tick(0, 1, 16'h0011 + 16'(k), 0, 0, "held_rep");
        end
        check("held_count", 32'(count), 32'd1);
        check("held_head", 32'(head_data), 32'h0011);
        idle(RW - 1, "held_wait");
        check("held_still", 32'(held), 32'd1);
        idle(1, "held_rearm");
        check("held_armed", 32'(held), 32'd0);

        // Terminal-count race: pulse on gap_cnt==RW-1 is a repeat.
        tick(1, 0, 16'h0, 0, 0, "race_rst");
        tick(0, 1, 16'h0021, 0, 0, "race_p0");
        idle(RW - 1, "race_gap");
        tick(0, 1, 16'h0022, 0, 0, "race_tc");
        check("race_nopush", 32'({count, held}), 32'({3'd1, 1'b1}));
        idle(RW, "race_gap2");
        tick(0, 1, 16'h0023, 0, 0, "race_push");
        check("race_pushed", 32'({count, head_data}), 32'({3'd2, 16'h0021}));

        // Fill and overflow, clear-vs-drop priority, then drain.
        tick(1, 0, 16'h0, 0, 0, "fill_rst");
        for (int v = 1; v <= 5; v++) press(16'(v), "fill_press");
        check("fill_state", 32'({full, count, overflow, head_data}),
              32'({1'b1, 3'd4, 1'b1, 16'h0001}));
        tick(0, 1, 16'h0006, 0, 1, "fill_clr_drop");
        check("fill_set_wins", 32'(overflow), 32'd1);
        idle(RW, "fill_gap");
        tick(0, 0, 16'h0, 0, 1, "fill_clr");
        check("fill_cleared", 32'(overflow), 32'd0);
        for (int v = 1; v <= 4; v++) begin
            check($sformatf("fill_pop%0d", v), 32'(head_data), 32'(v));
            tick(0, 0, 16'h0, 1, 0, "fill_pop");
        end
        check("fill_drained", 32'({empty, head_data}), 32'({1'b1, 16'h0000}));

        // Full FIFO with simultaneous push and pop.
        tick(1, 0, 16'h0, 0, 0, "fpp_rst");
        for (int v = 1; v <= 4; v++) press(16'(v), "fpp_press");
        tick(0, 1, 16'h0009, 1, 0, "fpp_both");
        check("fpp_state", 32'({count, overflow}), 32'({3'd4, 1'b0}));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("fpp_pop%0d", k), 32'(head_data), (k < 3) ? 32'(k + 2) : 32'h9);
            tick(0, 0, 16'h0, 1, 0, "fpp_pop");
        end

        // Reset while HELD with two entries.
        tick(1, 0, 16'h0, 0, 0, "mrst_rst0");
        press(16'h0031, "mrst_p1");
        tick(0, 1, 16'h0032, 0, 0, "mrst_p2");
        tick(1, 0, 16'h0, 0, 0, "mrst_rst");
        check("mrst_state", 32'({count, empty, held, overflow}), 32'({3'd0, 1'b1, 1'b0, 1'b0}));
        tick(0, 1, 16'h0033, 0, 0, "mrst_accept");
        check("mrst_push", 32'({count, head_data}), 32'({3'd1, 16'h0033}));

        // Randomized traffic with bursty pulse density.
        for (int n = 0; n < 3000; n++) begin
            int dens;
            dens = ((n / 200) % 2 == 0) ? 3 : 12;
            tick(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, dens - 1) == 0),
                 16'($urandom),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 15) == 0),
                 "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
